// File: rtl/video_ctrl_regs.sv
// ============================================================================
// Module      : video_ctrl_regs
// Description : Bus-responder register block for display control (fg/bg colour,
//               scroll) with vsync-synchronous shadow update, frame counter, IRQ.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module video_ctrl_regs #(
  parameter logic [11:0] FG_RESET     = 12'hFFF,
  parameter logic [11:0] BG_RESET     = 12'h000,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_data_ready,
  input  logic        i_vsync,
  output logic [11:0] o_fg_color,
  output logic [11:0] o_bg_color,
  output logic [4:0]  o_scroll_row,
  output logic        o_irq
);

  localparam logic [2:0] C_IDX_CTRL   = 3'd0;
  localparam logic [2:0] C_IDX_FG     = 3'd1;
  localparam logic [2:0] C_IDX_BG     = 3'd2;
  localparam logic [2:0] C_IDX_SCROLL = 3'd3;
  localparam logic [2:0] C_IDX_STATUS = 3'd4;

  logic        stb_prev_q, stb_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic        ack_q, ack_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [11:0] fg_sh_q, fg_sh_d, fg_act_q, fg_act_d;
  logic [11:0] bg_sh_q, bg_sh_d, bg_act_q, bg_act_d;
  logic [4:0]  scr_sh_q, scr_sh_d, scr_act_q, scr_act_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        irq_pend_q, irq_pend_d;
  logic        upd_pend_q, upd_pend_d;

  logic        w_accept, w_wr, w_rd, w_vs_ev, w_copy;
  logic [2:0]  w_idx;
  logic [31:0] w_rd_word;
  logic        w_unused;

  assign w_unused = ^{i_addr[1:0], i_data[31:12]};

  always_comb begin
    w_accept = i_cs & i_stb & ~stb_prev_q;
    w_wr     = w_accept & i_we;
    w_rd     = w_accept & ~i_we;
    w_idx    = i_addr[4:2];
    w_vs_ev  = (i_vsync == VSYNC_ACTIVE) && (vs_prev_q != VSYNC_ACTIVE);
    // Pending shadows go live at vsync, or as soon as shadow mode is switched off.
    w_copy   = upd_pend_q & (w_vs_ev | ~ctrl_q[1]);

    w_rd_word = 32'd0;
    case (w_idx)
      C_IDX_CTRL:   w_rd_word = {30'd0, ctrl_q};
      C_IDX_FG:     w_rd_word = {20'd0, fg_sh_q};
      C_IDX_BG:     w_rd_word = {20'd0, bg_sh_q};
      C_IDX_SCROLL: w_rd_word = {27'd0, scr_sh_q};
      C_IDX_STATUS: w_rd_word = {frame_cnt_q, 14'd0, upd_pend_q, irq_pend_q};
      default:      w_rd_word = 32'd0;
    endcase
  end

  always_comb begin
    stb_prev_d  = i_stb;
    vs_prev_d   = i_vsync;
    ack_d       = w_accept;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    fg_sh_d     = fg_sh_q;
    bg_sh_d     = bg_sh_q;
    scr_sh_d    = scr_sh_q;
    fg_act_d    = fg_act_q;
    bg_act_d    = bg_act_q;
    scr_act_d   = scr_act_q;
    frame_cnt_d = frame_cnt_q;
    irq_pend_d  = irq_pend_q;
    upd_pend_d  = upd_pend_q;

    if (w_rd) data_d = w_rd_word;

    // Copy uses the pre-write shadows; a same-cycle write then re-arms upd_pend.
    if (w_copy) begin
      fg_act_d   = fg_sh_q;
      bg_act_d   = bg_sh_q;
      scr_act_d  = scr_sh_q;
      upd_pend_d = 1'b0;
    end

    if (w_wr) begin
      case (w_idx)
        C_IDX_CTRL: ctrl_d = i_data[1:0];
        C_IDX_FG: begin
          fg_sh_d = i_data[11:0];
          if (ctrl_q[1]) upd_pend_d = 1'b1;
          else           fg_act_d   = i_data[11:0];
        end
        C_IDX_BG: begin
          bg_sh_d = i_data[11:0];
          if (ctrl_q[1]) upd_pend_d = 1'b1;
          else           bg_act_d   = i_data[11:0];
        end
        C_IDX_SCROLL: begin
          scr_sh_d = i_data[4:0];
          if (ctrl_q[1]) upd_pend_d = 1'b1;
          else           scr_act_d  = i_data[4:0];
        end
        C_IDX_STATUS: if (i_data[0]) irq_pend_d = 1'b0;
        default: ;
      endcase
    end

    if (w_vs_ev) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      irq_pend_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stb_prev_q  <= 1'b1;
      vs_prev_q   <= ~VSYNC_ACTIVE;
      ack_q       <= 1'b0;
      data_q      <= 32'd0;
      ctrl_q      <= 2'd0;
      fg_sh_q     <= FG_RESET;
      bg_sh_q     <= BG_RESET;
      scr_sh_q    <= 5'd0;
      fg_act_q    <= FG_RESET;
      bg_act_q    <= BG_RESET;
      scr_act_q   <= 5'd0;
      frame_cnt_q <= 16'd0;
      irq_pend_q  <= 1'b0;
      upd_pend_q  <= 1'b0;
    end else begin
      stb_prev_q  <= stb_prev_d;
      vs_prev_q   <= vs_prev_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      fg_sh_q     <= fg_sh_d;
      bg_sh_q     <= bg_sh_d;
      scr_sh_q    <= scr_sh_d;
      fg_act_q    <= fg_act_d;
      bg_act_q    <= bg_act_d;
      scr_act_q   <= scr_act_d;
      frame_cnt_q <= frame_cnt_d;
      irq_pend_q  <= irq_pend_d;
      upd_pend_q  <= upd_pend_d;
    end
  end

  // A reset landing in the ack cycle suppresses the acknowledge of the dropped transfer.
  assign o_data_ready = ack_q & ~i_rst;
  assign o_data       = data_q;
  assign o_fg_color   = fg_act_q;
  assign o_bg_color   = bg_act_q;
  assign o_scroll_row = scr_act_q;
  assign o_irq        = irq_pend_q & ctrl_q[0];

endmodule

`default_nettype wire

// File: tb/tb_video_ctrl_regs.sv
// ============================================================================
// Module      : tb_video_ctrl_regs
// Description : Self-checking bench for video_ctrl_regs (vector table + scoreboard).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_video_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst, cs, stb, we, vsync;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic        rdy, irq;
  logic [11:0] fg, bg;
  logic [4:0]  scroll;

  video_ctrl_regs dut (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_stb(stb), .i_we(we),
    .i_addr(addr), .i_data(wdata), .o_data(rdata), .o_data_ready(rdy),
    .i_vsync(vsync), .o_fg_color(fg), .o_bg_color(bg),
    .o_scroll_row(scroll), .o_irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every ack consumes one scoreboard entry; reads also compare the returned data.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.is_read) chk("rdata", rdata, e.exp);
        else           chk("wr_ack", {31'd0, rdy}, 32'd1);
      end
    end
  end

  task automatic push(input logic is_read, input logic [31:0] exp);
    sb_t e;
    e.is_read = is_read;
    e.exp     = exp;
    sb_q.push_back(e);
  endtask

  // Strobe one transfer; returns 2 time units into the ack cycle.
  task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input logic with_vs);
    @(posedge clk); #2;
    cs = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    if (with_vs) vsync = 1'b0;
    push(!w, exp);
    @(posedge clk); #2;
    cs = 1'b0; stb = 1'b0; vsync = 1'b1;
  endtask

  task automatic vs_pulse();
    @(posedge clk); #2; vsync = 1'b0;
    @(posedge clk); #2; vsync = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 5'd0,  32'h0000_0000, 32'h0};
    vecs[1]  = '{1'b1, 5'd4,  32'h0000_0ABC, 32'h0};
    vecs[2]  = '{1'b0, 5'd4,  32'h0,         32'h0000_0ABC};
    vecs[3]  = '{1'b1, 5'd8,  32'hFFFF_F456, 32'h0};
    vecs[4]  = '{1'b0, 5'd8,  32'h0,         32'h0000_0456};
    vecs[5]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, 5'd12, 32'h0,         32'h0000_001F};
    vecs[7]  = '{1'b0, 5'd7,  32'h0,         32'h0000_0ABC};
    vecs[8]  = '{1'b1, 5'd20, 32'h0000_0055, 32'h0};
    vecs[9]  = '{1'b0, 5'd20, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 5'd28, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 5'd0,  32'hFFFF_FFFC, 32'h0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         32'h0};
    vecs[13] = '{1'b0, 5'd16, 32'h0,         32'h0};

    rst = 1'b1; cs = 1'b0; stb = 1'b0; we = 1'b0; vsync = 1'b1;
    addr = 5'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_fg", {20'd0, fg}, 32'hFFF);
    chk("rst_bg", {20'd0, bg}, 32'h000);
    chk("rst_scroll", {27'd0, scroll}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Basic register access, live writes (shadow=0)
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp, 1'b0);
      if (i == 1) chk("fg_live", {20'd0, fg}, 32'hABC);
    end
    chk("bg_live", {20'd0, bg}, 32'h456);
    chk("scroll_live", {27'd0, scroll}, 32'h1F);

    // Shadowed BG write applied at vsync
    xfer(1'b1, 5'd0, 32'd2, 32'd0, 1'b0);
    xfer(1'b1, 5'd8, 32'h123, 32'd0, 1'b0);
    chk("bg_held", {20'd0, bg}, 32'h456);
    xfer(1'b0, 5'd16, 32'd0, 32'h0000_0002, 1'b0);
    vs_pulse();
    chk("bg_applied", {20'd0, bg}, 32'h123);
    xfer(1'b0, 5'd16, 32'd0, 32'h0001_0001, 1'b0);
    chk("irq_masked", {31'd0, irq}, 32'd0);

    // Frame counting and IRQ with W1C
    xfer(1'b1, 5'd16, 32'd1, 32'd0, 1'b0);
    xfer(1'b1, 5'd0, 32'd1, 32'd0, 1'b0);
    repeat (3) vs_pulse();
    xfer(1'b0, 5'd16, 32'd0, 32'h0004_0001, 1'b0);
    chk("irq_on", {31'd0, irq}, 32'd1);
    xfer(1'b1, 5'd16, 32'd1, 32'd0, 1'b0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    xfer(1'b0, 5'd16, 32'd0, 32'h0004_0000, 1'b0);

    // W1C colliding with vsync: set wins
    xfer(1'b1, 5'd16, 32'd1, 32'd0, 1'b1);
    chk("w1c_vs_irq", {31'd0, irq}, 32'd1);
    xfer(1'b0, 5'd16, 32'd0, 32'h0005_0001, 1'b0);

    // Shadow write colliding with vsync, then shadow mode switched off
    xfer(1'b1, 5'd0, 32'd3, 32'd0, 1'b0);
    xfer(1'b1, 5'd4, 32'h111, 32'd0, 1'b0);
    chk("fg_held", {20'd0, fg}, 32'hABC);
    xfer(1'b1, 5'd4, 32'h222, 32'd0, 1'b1);
    chk("fg_prewrite", {20'd0, fg}, 32'h111);
    xfer(1'b0, 5'd4, 32'd0, 32'h0000_0222, 1'b0);
    xfer(1'b0, 5'd16, 32'd0, 32'h0006_0003, 1'b0);
    xfer(1'b1, 5'd0, 32'd1, 32'd0, 1'b0);
    settle();
    chk("fg_unshadow", {20'd0, fg}, 32'h222);
    xfer(1'b0, 5'd16, 32'd0, 32'h0006_0001, 1'b0);

    // Held strobe gives one ack; deselected strobe is ignored
    @(posedge clk); #2;
    cs = 1'b1; stb = 1'b1; we = 1'b0; addr = 5'd4;
    push(1'b1, 32'h0000_0222);
    repeat (10) @(posedge clk);
    #2 cs = 1'b0; stb = 1'b0;
    @(posedge clk); #2;
    cs = 1'b0; stb = 1'b1; we = 1'b1; addr = 5'd4; wdata = 32'h999;
    @(posedge clk); #2 stb = 1'b0;
    settle();
    chk("cs0_fg", {20'd0, fg}, 32'h222);
    xfer(1'b0, 5'd4, 32'd0, 32'h0000_0222, 1'b0);

    // Reset in the ack cycle of a read
    @(posedge clk); #2;
    cs = 1'b1; stb = 1'b1; we = 1'b0; addr = 5'd16;
    @(posedge clk); #2;
    rst = 1'b1; cs = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, rdy}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rst2_ready", {31'd0, rdy}, 32'd0);
    chk("rst2_data", rdata, 32'd0);
    chk("rst2_fg", {20'd0, fg}, 32'hFFF);
    chk("rst2_bg", {20'd0, bg}, 32'h000);
    chk("rst2_scroll", {27'd0, scroll}, 32'd0);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    xfer(1'b0, 5'd16, 32'd0, 32'h0000_0000, 1'b0);

    // Frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    xfer(1'b0, 5'd16, 32'd0, 32'hFFFF_0000, 1'b0);
    vs_pulse();
    xfer(1'b0, 5'd16, 32'd0, 32'h0000_0001, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
